// File: rtl/display_pkg.sv
// Shared definitions for the display datapath: converter FSM states and BCD digit width.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] i_d,
    output logic [BCD_W-1:0] o_d
);

    assign o_d = (i_d >= BCD_W'(5)) ? i_d + BCD_W'(3) : i_d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per cycle, with held outputs.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int N       = 32,
    parameter int DIGITS  = 8,
    parameter int CDIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int                CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int                ACC_W    = BCD_W * CDIGITS;
    localparam int                OUT_W    = BCD_W * DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [N-1:0]       r_sh_bin;
    logic [OUT_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;

    logic [ACC_W-1:0]   w_acc_adj;
    logic [ACC_W-1:0]   w_acc_next;

    for (genvar g = 0; g < CDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d (r_acc[g*BCD_W +: BCD_W]),
            .o_d (w_acc_adj[g*BCD_W +: BCD_W])
        );
    end

    // Top binary bit enters the accumulator LSB as the pair shifts left.
    assign w_acc_next = {w_acc_adj[ACC_W-2:0], r_sh_bin[N-1]};

    // NOTE: all state here is registered with <= so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_sh_bin   <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh_bin <= bin;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc    <= w_acc_next;
                    r_sh_bin <= r_sh_bin << 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Result is published on entry to DONE so it is valid alongside the done pulse.
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_bcd      <= w_acc_next[OUT_W-1:0];
                        r_overflow <= |w_acc_next[ACC_W-1:OUT_W];
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: decimal-arithmetic reference model checked every cycle plus directed literal checks.
module tb_bin_to_bcd_seq;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  bin = '0;
    logic          busy;
    logic          done;
    logic [31:0]   bcd;
    logic          overflow;

    int n_vec  = 0;
    int n_fail = 0;

    bin_to_bcd_seq #(.N(N), .DIGITS(8), .CDIGITS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [31:0]     r;
        x = 64'(v);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic to_ovf(input logic [31:0] v);
        return 64'(v) >= 64'd100000000;
    endfunction

    // Reference timeline: m_age counts cycles since acceptance (0 = idle).
    int          m_age = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_bcd = '0;
    logic        m_ovf = 1'b0;
    logic        check_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_age = 0;
            m_bcd = '0;
            m_ovf = 1'b0;
        end else if (m_age == 0) begin
            if (start) begin
                m_age = 1;
                m_val = bin;
            end
        end else if (m_age == N + 1) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == N + 1) begin
                m_bcd = to_bcd(m_val);
                m_ovf = to_ovf(m_val);
            end
        end
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 64'(busy), 64'(m_age >= 1 && m_age <= N));
            check("done", 64'(done), 64'(m_age == N + 1));
            check("bcd", 64'(bcd), 64'(m_bcd));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // Called just after a posedge; leaves the bench just after the accepting posedge (cycle 1).
    task automatic do_start(input logic [31:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #2;
        start = 1'b0;
        bin   = $urandom;
    endtask

    // Counts negedges until done; cyc = 1 for the first negedge seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_conv(input string name, input logic [31:0] v,
                            input logic [31:0] exp_bcd, input logic exp_ovf);
        int cyc;
        @(posedge clk); #2;
        do_start(v);
        wait_done(cyc);
        check({name, "_latency"}, 64'(cyc), 64'(N + 1));
        check({name, "_bcd"}, 64'(bcd), 64'(exp_bcd));
        check({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  saw_done;

        check("model_12345678", 64'(to_bcd(32'd12345678)), 64'h12345678);
        check("model_ffffffff", 64'(to_bcd(32'hFFFFFFFF)), 64'h94967295);
        check("model_ovf_1e8", 64'(to_ovf(32'd100000000)), 64'd1);
        check("model_ovf_max8", 64'(to_ovf(32'd99999999)), 64'd0);

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bcd", 64'(bcd), 64'h0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        run_conv("zero", 32'd0, 32'h00000000, 1'b0);

        // busy must be high exactly during cycles 1..32.
        @(posedge clk); #2;
        do_start(32'd12345678);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == 1 || k == N) check("busy_window", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("seq_done", 64'(done), 64'd1);
        check("seq_bcd", 64'(bcd), 64'h12345678);
        check("seq_ovf", 64'(overflow), 64'd0);

        run_conv("max8", 32'd99999999, 32'h99999999, 1'b0);
        run_conv("1e8", 32'd100000000, 32'h00000000, 1'b1);
        run_conv("allones", 32'hFFFFFFFF, 32'h94967295, 1'b1);

        // Start while busy is ignored; next start right after DONE is accepted.
        @(posedge clk); #2;
        do_start(32'd5);
        repeat (9) begin
            @(posedge clk); #2;
        end
        start = 1'b1;
        bin   = 32'd7;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(cyc);
        check("ignore_latency", 64'(cyc + 10), 64'(N + 1));
        check("ignore_bcd", 64'(bcd), 64'h5);
        @(posedge clk); #2;
        do_start(32'd31);
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("restart_latency", 64'(cyc + 1), 64'(N + 1));
        check("restart_bcd", 64'(bcd), 64'h31);

        run_conv("five", 32'd5, 32'h00000005, 1'b0);

        // Reset mid-conversion: aborts, clears result, no done pulse.
        @(posedge clk); #2;
        do_start(32'd42);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check("hold_bcd", 64'(bcd), 64'h5);
            @(posedge clk); #2;
        end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("abort_bcd", 64'(bcd), 64'h0);
        check("abort_busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
